// File: rtl/accelerator_write_heads_parser.sv
// Write-heads parser: splits a serial xi stream into per-field strobed buses.
// Optional macro ACCELERATOR_WRITE_HEADS_CLAMP_EN saturates E/GA/GW to [0, ONE].
module accelerator_write_heads_parser #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int HEADS        = 4,
    parameter int W_MAX        = 64,
    parameter int FRAC         = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
    input  logic                    XI_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    XI_IN,
    output logic [CONTROL_SIZE-1:0] HEAD_OUT,
    output logic [CONTROL_SIZE-1:0] INDEX_OUT,
    output logic                    K_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    K_OUT,
    output logic                    BETA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    BETA_OUT,
    output logic                    E_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    E_OUT,
    output logic                    V_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    V_OUT,
    output logic                    GA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    GA_OUT,
    output logic                    GW_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    GW_OUT
);

    typedef enum logic [2:0] {
        IDLE, K, BETA, E, V, GA, GW
    } state_t;

    localparam logic [CONTROL_SIZE-1:0] WMAX_C = CONTROL_SIZE'(W_MAX);
    localparam logic [CONTROL_SIZE-1:0] LAST_H = CONTROL_SIZE'(HEADS - 1);

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] ws_q, ws_d;
    logic [CONTROL_SIZE-1:0] head_q, head_d;
    logic [CONTROL_SIZE-1:0] idx_q, idx_d;
    logic [CONTROL_SIZE-1:0] ws_start;
    logic                    idx_last;
    logic [DATA_SIZE-1:0]    sat_in;

    logic                    ready_d;
    logic [CONTROL_SIZE-1:0] head_out_d, index_out_d;
    logic                    k_en_d, beta_en_d, e_en_d, v_en_d, ga_en_d, gw_en_d;
    logic [DATA_SIZE-1:0]    k_d, beta_d, e_d, v_d, ga_d, gw_d;

`ifdef ACCELERATOR_WRITE_HEADS_CLAMP_EN
    localparam logic [DATA_SIZE-1:0] ONE =
        {{(DATA_SIZE-1){1'b0}}, 1'b1} << FRAC;

    // Saturate gate/erase words to [0, ONE] ahead of the output register
    always_comb begin
        sat_in = XI_IN;
        if (XI_IN[DATA_SIZE-1])
            sat_in = '0;
        else if (XI_IN > ONE)
            sat_in = ONE;
    end
`else
    assign sat_in = XI_IN;
`endif

    assign ws_start = (SIZE_W_IN > WMAX_C) ? WMAX_C : SIZE_W_IN;
    assign idx_last = (idx_q == ws_q - 1'b1);

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= IDLE;
            ws_q            <= '0;
            head_q          <= '0;
            idx_q           <= '0;
            READY           <= 1'b0;
            HEAD_OUT        <= '0;
            INDEX_OUT       <= '0;
            K_OUT_ENABLE    <= 1'b0;
            BETA_OUT_ENABLE <= 1'b0;
            E_OUT_ENABLE    <= 1'b0;
            V_OUT_ENABLE    <= 1'b0;
            GA_OUT_ENABLE   <= 1'b0;
            GW_OUT_ENABLE   <= 1'b0;
            K_OUT           <= '0;
            BETA_OUT        <= '0;
            E_OUT           <= '0;
            V_OUT           <= '0;
            GA_OUT          <= '0;
            GW_OUT          <= '0;
        end else begin
            state_q         <= state_d;
            ws_q            <= ws_d;
            head_q          <= head_d;
            idx_q           <= idx_d;
            READY           <= ready_d;
            HEAD_OUT        <= head_out_d;
            INDEX_OUT       <= index_out_d;
            K_OUT_ENABLE    <= k_en_d;
            BETA_OUT_ENABLE <= beta_en_d;
            E_OUT_ENABLE    <= e_en_d;
            V_OUT_ENABLE    <= v_en_d;
            GA_OUT_ENABLE   <= ga_en_d;
            GW_OUT_ENABLE   <= gw_en_d;
            K_OUT           <= k_d;
            BETA_OUT        <= beta_d;
            E_OUT           <= e_d;
            V_OUT           <= v_d;
            GA_OUT          <= ga_d;
            GW_OUT          <= gw_d;
        end
    end

    // Next-state, counter and output decode; stalls when no xi word
    always_comb begin
        state_d     = state_q;
        ws_d        = ws_q;
        head_d      = head_q;
        idx_d       = idx_q;
        ready_d     = 1'b0;
        head_out_d  = HEAD_OUT;
        index_out_d = INDEX_OUT;
        k_en_d      = 1'b0;
        beta_en_d   = 1'b0;
        e_en_d      = 1'b0;
        v_en_d      = 1'b0;
        ga_en_d     = 1'b0;
        gw_en_d     = 1'b0;
        k_d         = K_OUT;
        beta_d      = BETA_OUT;
        e_d         = E_OUT;
        v_d         = V_OUT;
        ga_d        = GA_OUT;
        gw_d        = GW_OUT;

        case (state_q)
            IDLE: begin
                if (START) begin
                    ws_d    = ws_start;
                    head_d  = '0;
                    idx_d   = '0;
                    state_d = (ws_start == '0) ? BETA : K;
                end
            end
            K: begin
                if (XI_IN_ENABLE) begin
                    k_en_d      = 1'b1;
                    k_d         = XI_IN;
                    head_out_d  = head_q;
                    index_out_d = idx_q;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = BETA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            BETA: begin
                if (XI_IN_ENABLE) begin
                    beta_en_d   = 1'b1;
                    beta_d      = XI_IN;
                    head_out_d  = head_q;
                    index_out_d = '0;
                    state_d     = (ws_q == '0) ? GA : E;
                end
            end
            E: begin
                if (XI_IN_ENABLE) begin
                    e_en_d      = 1'b1;
                    e_d         = sat_in;
                    head_out_d  = head_q;
                    index_out_d = idx_q;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = V;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            V: begin
                if (XI_IN_ENABLE) begin
                    v_en_d      = 1'b1;
                    v_d         = XI_IN;
                    head_out_d  = head_q;
                    index_out_d = idx_q;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = GA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            GA: begin
                if (XI_IN_ENABLE) begin
                    ga_en_d     = 1'b1;
                    ga_d        = sat_in;
                    head_out_d  = head_q;
                    index_out_d = '0;
                    state_d     = GW;
                end
            end
            GW: begin
                if (XI_IN_ENABLE) begin
                    gw_en_d     = 1'b1;
                    gw_d        = sat_in;
                    head_out_d  = head_q;
                    index_out_d = '0;
                    if (head_q == LAST_H) begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        head_d  = head_q + 1'b1;
                        state_d = (ws_q == '0) ? BETA : K;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
